// File: rtl/core_accu_pkg.sv
// core_accu_pkg: shared widths, saturation limits and two-state encoding for the accumulation stage
package core_accu_pkg;
  localparam int ACCU_IDATA_WIDTH = 16;
  localparam int ACCU_ODATA_WIDTH = 24;
  localparam int CDATA_ACCU_NUM_WIDTH = 10;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/core_accu_if.sv
// core_accu_if: valid-only input/output bundle between the MAC array, the accumulator and the quantizer
interface core_accu_if #(
  parameter int IDATA_WIDTH = 16,
  parameter int ODATA_WIDTH = 24,
  parameter int CDATA_ACCU_NUM_WIDTH = 10
);
  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num;
  logic acc_clear;
  logic signed [IDATA_WIDTH-1:0] idata;
  logic idata_valid;
  logic signed [ODATA_WIDTH-1:0] odata;
  logic odata_valid;
  logic odata_ovf;
  modport master (
    output cfg_acc_num, acc_clear, idata, idata_valid,
    input odata, odata_valid, odata_ovf
  );
  modport slave (
    input cfg_acc_num, acc_clear, idata, idata_valid,
    output odata, odata_valid, odata_ovf
  );
endinterface

// File: rtl/core_accu_addsat.sv
// core_accu_addsat: widened signed add with overflow detect; clamps when CORE_ACCU_SATURATE_EN is defined, wraps otherwise
module core_accu_addsat
  import core_accu_pkg::*;
#(
  parameter int IW = 16,
  parameter int OW = 24
) (
  input  logic signed [OW-1:0] acc_i,
  input  logic signed [IW-1:0] din_i,
  output logic signed [OW-1:0] sum_o,
  output logic                 ovf_o
);
  logic signed [OW:0] sum;
  assign sum = {acc_i[OW-1], acc_i} + {{(OW + 1 - IW){din_i[IW-1]}}, din_i};
  assign ovf_o = sum[OW] ^ sum[OW-1];
`ifdef CORE_ACCU_SATURATE_EN
  assign sum_o = ovf_o ? (sum[OW] ? OW'(sat_min(OW)) : OW'(sat_max(OW))) : sum[OW-1:0];
`else
  assign sum_o = sum[OW-1:0];
`endif
endmodule

// File: rtl/core_accu.sv
// core_accu: sums groups of signed partial products and pulses each group sum to the quantizer
// Build option: CORE_ACCU_SATURATE_EN selects clamping instead of wrapping on overflow.
module core_accu #(
  parameter int IDATA_WIDTH = core_accu_pkg::ACCU_IDATA_WIDTH,
  parameter int ODATA_WIDTH = core_accu_pkg::ACCU_ODATA_WIDTH,
  parameter int CDATA_ACCU_NUM_WIDTH = core_accu_pkg::CDATA_ACCU_NUM_WIDTH
) (
  input logic clk,
  input logic rst,
  core_accu_if.slave acc_if
);
  import core_accu_pkg::*;
  localparam int CW = CDATA_ACCU_NUM_WIDTH;
  localparam int OW = ODATA_WIDTH;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt, num_lat_q, num_lat_d, num_eff;
  logic signed [OW-1:0] acc_q, acc_d, add_a, sum, odata_q, odata_d;
  logic ovf_q, ovf_d, ovf, ovf_all, start, done, odv_q, odo_q;
  logic [0:0] state;
  core_accu_addsat #(.IW(IDATA_WIDTH), .OW(OW)) u_addsat (
    .acc_i(add_a),
    .din_i(acc_if.idata),
    .sum_o(sum),
    .ovf_o(ovf)
  );
  // A clear with a concurrent input drops the old group and restarts from that input.
  always_comb begin
    state = cnt_q == '0 ? ST_IDLE : ST_ACCUM;
    start = acc_if.idata_valid && (state == ST_IDLE || acc_if.acc_clear);
    num_eff = start ? (acc_if.cfg_acc_num == '0 ? CW'(1) : acc_if.cfg_acc_num) : num_lat_q;
    cnt_nxt = start ? CW'(1) : cnt_q + CW'(1);
    add_a = start ? '0 : acc_q;
    done = acc_if.idata_valid && cnt_nxt == num_eff;
    ovf_all = (ovf_q && !start) || ovf;
    cnt_d = acc_if.idata_valid ? (done ? '0 : cnt_nxt) : (acc_if.acc_clear ? '0 : cnt_q);
    ovf_d = acc_if.idata_valid ? (!done && ovf_all) : (ovf_q && !acc_if.acc_clear);
    acc_d = acc_if.idata_valid ? sum : acc_q;
    num_lat_d = num_eff;
    odata_d = done ? sum : odata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      num_lat_q <= CW'(1);
      acc_q <= '0;
      ovf_q <= 1'b0;
      odata_q <= '0;
      odv_q <= 1'b0;
      odo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      num_lat_q <= num_lat_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      odata_q <= odata_d;
      odv_q <= done;
      odo_q <= done && ovf_all;
    end
  end
  assign acc_if.odata = odata_q;
  assign acc_if.odata_valid = odv_q;
  assign acc_if.odata_ovf = odo_q;
endmodule
